sdpram_dds_ctrl: RTL
====================

Name: sdpram_dds_ctrl

Overview:
- Single-clock sequencer for the 32-bit x 1024 simple dual-port table RAM (port A write, port B read).
- Two main jobs:
  - LOAD: fills the table from a valid/ready write stream.
  - PLAY: drives port B from a phase accumulator to produce a continuous DDS sample stream.
- During PLAY, accepts single-word live table updates on port A and resolves same-address read/write collisions.
- Sits between the host/table loader and the RAM IP; output feeds the DDS sample path.

Parameters:
- DW, 32, RAM data width.
- AW, 10, RAM address width; DEPTH = 2**AW.
- PW, 32, phase accumulator width; PW >= AW.
- RD_LAT, 1, RAM port-B read latency in cycles; legal values 1 or 2.

Ports:
- clk  in  1  system clock; RAM clka and clkb are tied to it.
- rst_n  in  1  asynchronous active-low reset.
- start_load  in  1  pulse; request a table load.
- wr_valid  in  1  load-stream data valid.
- wr_data  in  DW  load-stream data.
- wr_ready  out  1  load-stream ready.
- load_done  out  1  one-cycle pulse after the last load word is accepted.
- table_valid  out  1  table fully loaded since reset.
- play_en  in  1  level; run playback.
- freq_word  in  PW  phase increment, sampled every PLAY cycle.
- upd_valid  in  1  live-update request.
- upd_addr  in  AW  live-update address.
- upd_data  in  DW  live-update data.
- upd_ready  out  1  live-update ready.
- ram_wea  out  1  RAM port-A write enable.
- ram_addra  out  AW  RAM port-A address.
- ram_dina  out  DW  RAM port-A data.
- ram_addrb  out  AW  RAM port-B address.
- ram_doutb  in  DW  RAM port-B data.
- sample_out  out  DW  playback sample.
- sample_valid  out  1  sample_out valid.
- state_o  out  2  state: 0 IDLE, 1 LOAD, 2 PLAY.

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE; table_valid, load_done, wr_ready, upd_ready, ram_wea, sample_valid all 0.
  - ram_addra, ram_dina, ram_addrb, sample_out, phase accumulator and load counter all 0.
  - Reset during LOAD or PLAY aborts the operation; table_valid returns 0 and a full reload is required.
- IDLE:
  - start_load=1 -> LOAD, load counter cleared.
  - Otherwise play_en=1 and table_valid=1 -> PLAY, phase cleared to 0.
  - start_load and play_en high together: LOAD wins.
- LOAD:
  - wr_ready=1 throughout.
  - Each wr_valid&&wr_ready beat registers ram_wea=1, ram_addra=counter, ram_dina=wr_data on the next cycle, then counter increments.
  - Gaps in wr_valid give ram_wea=0.
  - Acceptance of beat DEPTH-1: next cycle load_done=1 for one cycle, table_valid=1, state IDLE.
  - play_en and upd_valid are ignored in LOAD.
- PLAY:
  - ram_addrb = phase[PW-1:PW-AW], combinational from the phase register.
  - Each cycle, phase <= phase + freq_word, modulo 2**PW; wrap is silent.
  - First PLAY cycle presents address 0.
  - sample_out is registered. The sample for an address presented in cycle N appears in cycle N+RD_LAT+1 with sample_valid=1.
  - With freq_word constant, sample_valid is continuous.
- Leaving PLAY:
  - play_en=0 -> IDLE next cycle.
  - The valid pipeline drains: the last RD_LAT+1 in-flight samples are still emitted, then sample_valid=0.
  - start_load in PLAY is ignored.
- Live update:
  - upd_ready=1 only in PLAY.
  - Each upd_valid&&upd_ready registers a port-A write next cycle, as in LOAD.
  - Port-A writes never issue outside LOAD/PLAY.
- Collision:
  - Condition: in the same cycle, the registered port-A write address equals the current ram_addrb.
  - The resulting sample is handled per the optional feature.
  - The collision match and data are pipelined alongside the read.

Optional Feature:
- Macro SDPRAM_COLLISION_BYPASS_EN.
- Defined: on collision, sample_out takes the colliding ram_dina (write-first forwarding), independent of the RAM IP's collision mode.
- Undefined: sample_out = ram_doutb unmodified. Output port coll_flag (1 bit, reset 0) pulses high, aligned with the affected sample_valid, so the bench and system can mark the sample as undefined.

Test Plan:
- Load: start_load, 1024 beats wr_data=i*i, no gaps -> ram_wea high 1024 consecutive cycles, addresses 0..1023; load_done one pulse; table_valid=1.
- Load with backpressure gaps: wr_valid toggles every other cycle -> exactly 1024 writes, addresses contiguous; load_done only after beat 1023.
- Play with freq_word=2**22 (step 1 address/cycle, PW=32, AW=10): first sample 0 at RD_LAT+1 cycles after PLAY entry, then 1, 4, 9...; wraps from 1023*1023 to 0 with sample_valid continuous.
- Play with freq_word=2**21 (each address read twice): sample sequence 0,0,1,1,4,4...; then play_en=0 -> exactly RD_LAT+1 further valid samples, then sample_valid=0.
- Live update during play: upd_addr=5, upd_data=0xDEADBEEF while addrb=5 -> with macro that sample is 0xDEADBEEF; without macro coll_flag pulses on that sample; next pass over address 5 reads 0xDEADBEEF in both builds.
- Reset mid-LOAD after 300 beats -> all outputs at reset values, table_valid=0; play_en=1 then keeps state IDLE until a full reload completes.

Source files
------------

// File: rtl/sdpram_dds_ctrl_if.sv
// Host, table-loader, RAM and sample-path signals around sdpram_dds_ctrl.
// The slave modport is the controller's view; master is the environment's view.
interface sdpram_dds_ctrl_if #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 10,
  parameter int unsigned PW = 32
);
  // table load stream
  logic          start_load;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          load_done;
  logic          table_valid;
  // playback control and live updates
  logic          play_en;
  logic [PW-1:0] freq_word;
  logic          upd_valid;
  logic [AW-1:0] upd_addr;
  logic [DW-1:0] upd_data;
  logic          upd_ready;
  // RAM ports
  logic          ram_wea;
  logic [AW-1:0] ram_addra;
  logic [DW-1:0] ram_dina;
  logic [AW-1:0] ram_addrb;
  logic [DW-1:0] ram_doutb;
  // sample path and status
  logic [DW-1:0] sample_out;
  logic          sample_valid;
  logic          coll_flag;
  logic [1:0]    state_o;

  modport slave (
    input  start_load, wr_valid, wr_data, play_en, freq_word,
           upd_valid, upd_addr, upd_data, ram_doutb,
    output wr_ready, load_done, table_valid, upd_ready,
           ram_wea, ram_addra, ram_dina, ram_addrb,
           sample_out, sample_valid, coll_flag, state_o
  );

  modport master (
    output start_load, wr_valid, wr_data, play_en, freq_word,
           upd_valid, upd_addr, upd_data, ram_doutb,
    input  wr_ready, load_done, table_valid, upd_ready,
           ram_wea, ram_addra, ram_dina, ram_addrb,
           sample_out, sample_valid, coll_flag, state_o
  );
endinterface

// File: rtl/sdpram_dds_ctrl.sv
// Load/playback sequencer for a simple dual-port DDS table RAM (A write, B read).
// SDPRAM_COLLISION_BYPASS_EN: forward colliding write data to the sample; otherwise flag it on coll_flag.
module sdpram_dds_ctrl #(
  parameter int unsigned DW     = 32,
  parameter int unsigned AW     = 10,
  parameter int unsigned PW     = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  sdpram_dds_ctrl_if.slave bus_io
);

  localparam int unsigned CDW = RD_LAT * DW;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2
  } state_e;

  state_e        state_q;
  logic [AW-1:0] cnt_q;
  logic [PW-1:0] phase_q;
  logic          wr_ready_q;
  logic          upd_ready_q;
  logic          load_done_q;
  logic          table_valid_q;
  logic          wea_q;
  logic [AW-1:0] addra_q;
  logic [DW-1:0] dina_q;

  logic [RD_LAT-1:0] rv_q;
  logic [RD_LAT-1:0] coll_q;
  logic [DW-1:0]     sample_q;
  logic              sample_valid_q;

  logic          wr_fire_c;
  logic          upd_fire_c;
  logic          issue_c;
  logic          coll_c;
  logic [AW-1:0] addrb_c;

  // Table index is the top AW bits of the phase accumulator.
  assign addrb_c    = phase_q[PW-1 -: AW];
  assign wr_fire_c  = wr_ready_q & bus_io.wr_valid;
  assign upd_fire_c = upd_ready_q & bus_io.upd_valid;
  assign issue_c    = (state_q == ST_PLAY);
  assign coll_c     = issue_c & wea_q & (addra_q == addrb_c);

  // Control FSM; ready flags are registered so they track the state register exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      phase_q       <= '0;
      wr_ready_q    <= 1'b0;
      upd_ready_q   <= 1'b0;
      load_done_q   <= 1'b0;
      table_valid_q <= 1'b0;
      wea_q         <= 1'b0;
      addra_q       <= '0;
      dina_q        <= '0;
    end else begin
      load_done_q <= 1'b0;
      wea_q       <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus_io.start_load) begin
            state_q    <= ST_LOAD;
            cnt_q      <= '0;
            wr_ready_q <= 1'b1;
          end else if (bus_io.play_en && table_valid_q) begin
            state_q     <= ST_PLAY;
            phase_q     <= '0;
            upd_ready_q <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (wr_fire_c) begin
            wea_q   <= 1'b1;
            addra_q <= cnt_q;
            dina_q  <= bus_io.wr_data;
            cnt_q   <= cnt_q + AW'(1);
            if (cnt_q == '1) begin
              state_q       <= ST_IDLE;
              wr_ready_q    <= 1'b0;
              load_done_q   <= 1'b1;
              table_valid_q <= 1'b1;
            end
          end
        end
        ST_PLAY: begin
          phase_q <= phase_q + bus_io.freq_word;
          if (upd_fire_c) begin
            wea_q   <= 1'b1;
            addra_q <= bus_io.upd_addr;
            dina_q  <= bus_io.upd_data;
          end
          if (!bus_io.play_en) begin
            state_q     <= ST_IDLE;
            upd_ready_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          wr_ready_q  <= 1'b0;
          upd_ready_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef SDPRAM_COLLISION_BYPASS_EN
  logic [CDW-1:0] cdat_q;

  // Read pipeline: valid, collision match and colliding data travel with the RAM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv_q           <= '0;
      coll_q         <= '0;
      cdat_q         <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
    end else begin
      rv_q           <= RD_LAT'({rv_q, issue_c});
      coll_q         <= RD_LAT'({coll_q, coll_c});
      cdat_q         <= CDW'({cdat_q, dina_q});
      sample_valid_q <= rv_q[RD_LAT-1];
      if (rv_q[RD_LAT-1]) begin
        sample_q <= coll_q[RD_LAT-1] ? cdat_q[CDW-1 -: DW] : bus_io.ram_doutb;
      end
    end
  end

  assign bus_io.coll_flag = 1'b0;
`else
  logic coll_flag_q;

  // Read pipeline: valid and collision match travel with the RAM read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rv_q           <= '0;
      coll_q         <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      coll_flag_q    <= 1'b0;
    end else begin
      rv_q           <= RD_LAT'({rv_q, issue_c});
      coll_q         <= RD_LAT'({coll_q, coll_c});
      sample_valid_q <= rv_q[RD_LAT-1];
      coll_flag_q    <= rv_q[RD_LAT-1] & coll_q[RD_LAT-1];
      if (rv_q[RD_LAT-1]) begin
        sample_q <= bus_io.ram_doutb;
      end
    end
  end

  assign bus_io.coll_flag = coll_flag_q;
`endif

  assign bus_io.wr_ready     = wr_ready_q;
  assign bus_io.upd_ready    = upd_ready_q;
  assign bus_io.load_done    = load_done_q;
  assign bus_io.table_valid  = table_valid_q;
  assign bus_io.ram_wea      = wea_q;
  assign bus_io.ram_addra    = addra_q;
  assign bus_io.ram_dina     = dina_q;
  assign bus_io.ram_addrb    = addrb_c;
  assign bus_io.sample_out   = sample_q;
  assign bus_io.sample_valid = sample_valid_q;
  assign bus_io.state_o      = state_q;

endmodule
